// File: rtl/adc_spi_master.sv
// adc_spi_master: 3-wire SPI master for ADC register access (24-bit frame: R/W, W1, W0, A12..A0, D7..D0).
// Readback is compiled in only when ADC_SPI_READBACK_EN is defined; otherwise every request is a write.
module adc_spi_master #(
    parameter int CLK_DIV = 50
) (
    input  logic        i_clock,
    input  logic        i_RESET,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_rw,
    input  logic [12:0] i_addr,
    input  logic [7:0]  i_data,
    output logic [7:0]  o_rdata,
    output logic        o_done,
    output logic        o_sclk,
    output logic        o_csb,
    output logic        o_sdio,
    output logic        o_sdio_oe,
    input  logic        i_sdio
);

`ifdef ADC_SPI_READBACK_EN
    localparam logic READBACK = 1'b1;
`else
    localparam logic READBACK = 1'b0;
`endif

    localparam logic [9:0] CNT_LAST = 10'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t      state_r, state_s;
    logic [9:0]  cnt_r, cnt_s;
    logic [4:0]  bit_r, bit_s;
    logic        hi_r, hi_s;
    logic [23:0] frame_r, frame_s;
    logic        rw_r, rw_s;
    logic [7:0]  rx_r, rx_s;
    logic        sclk_r, sclk_s;
    logic        csb_r, csb_s;
    logic        sdio_r, sdio_s;
    logic        oe_r, oe_s;
    logic        ready_r, ready_s;
    logic        done_r, done_s;
    logic [7:0]  rdata_r, rdata_s;
    logic        cnt_end_s;

    // Next-state and next-output computation; all outputs leave through registers.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        bit_s     = bit_r;
        hi_s      = hi_r;
        frame_s   = frame_r;
        rw_s      = rw_r;
        rx_s      = rx_r;
        sclk_s    = sclk_r;
        csb_s     = csb_r;
        sdio_s    = sdio_r;
        oe_s      = oe_r;
        ready_s   = ready_r;
        done_s    = 1'b0;
        rdata_s   = rdata_r;
        cnt_end_s = (cnt_r == CNT_LAST);

        case (state_r)
            IDLE: begin
                if (i_valid && ready_r) begin
                    state_s = SETUP;
                    cnt_s   = 10'd0;
                    rw_s    = i_rw & READBACK;
                    frame_s = {i_rw & READBACK, 2'b00, i_addr, i_data};
                    sdio_s  = i_rw & READBACK;
                    csb_s   = 1'b0;
                    sclk_s  = 1'b0;
                    oe_s    = 1'b1;
                    ready_s = 1'b0;
                end else begin
                    ready_s = 1'b1;
                    csb_s   = 1'b1;
                    sclk_s  = 1'b0;
                end
            end
            SETUP: begin
                if (cnt_end_s) begin
                    state_s = SHIFT;
                    cnt_s   = 10'd0;
                    bit_s   = 5'd0;
                    hi_s    = 1'b0;
                end else begin
                    cnt_s = cnt_r + 10'd1;
                end
            end
            SHIFT: begin
                if (!cnt_end_s) begin
                    cnt_s = cnt_r + 10'd1;
                end else begin
                    cnt_s = 10'd0;
                    if (!hi_r) begin
                        // Rising SCLK: the ADC's read data has been stable since the previous fall.
                        hi_s   = 1'b1;
                        sclk_s = 1'b1;
                        if (rw_r && (bit_r >= 5'd16)) begin
                            rx_s = {rx_r[6:0], i_sdio};
                        end else begin
                            rx_s = rx_r;
                        end
                    end else if (bit_r == 5'd23) begin
                        state_s = HOLD;
                        hi_s    = 1'b0;
                        sclk_s  = 1'b0;
                    end else begin
                        bit_s   = bit_r + 5'd1;
                        hi_s    = 1'b0;
                        sclk_s  = 1'b0;
                        frame_s = {frame_r[22:0], 1'b0};
                        sdio_s  = frame_r[22];
                        if (rw_r && (bit_r == 5'd15)) begin
                            oe_s = 1'b0;
                        end else begin
                            oe_s = oe_r;
                        end
                    end
                end
            end
            HOLD: begin
                if (cnt_end_s) begin
                    state_s = GAP;
                    cnt_s   = 10'd0;
                    csb_s   = 1'b1;
                    oe_s    = 1'b1;
                end else begin
                    cnt_s = cnt_r + 10'd1;
                end
            end
            GAP: begin
                if (cnt_end_s) begin
                    state_s = IDLE;
                    cnt_s   = 10'd0;
                    ready_s = 1'b1;
                    done_s  = 1'b1;
                    if (rw_r) begin
                        rdata_s = rx_r;
                    end else begin
                        rdata_s = rdata_r;
                    end
                end else begin
                    cnt_s = cnt_r + 10'd1;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 10'd0;
                csb_s   = 1'b1;
                sclk_s  = 1'b0;
                oe_s    = 1'b1;
                ready_s = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clock) begin
        if (i_RESET) begin
            state_r <= IDLE;
            cnt_r   <= 10'd0;
            bit_r   <= 5'd0;
            hi_r    <= 1'b0;
            frame_r <= 24'd0;
            rw_r    <= 1'b0;
            rx_r    <= 8'd0;
            sclk_r  <= 1'b0;
            csb_r   <= 1'b1;
            sdio_r  <= 1'b0;
            oe_r    <= 1'b1;
            ready_r <= 1'b1;
            done_r  <= 1'b0;
            rdata_r <= 8'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            bit_r   <= bit_s;
            hi_r    <= hi_s;
            frame_r <= frame_s;
            rw_r    <= rw_s;
            rx_r    <= rx_s;
            sclk_r  <= sclk_s;
            csb_r   <= csb_s;
            sdio_r  <= sdio_s;
            oe_r    <= oe_s;
            ready_r <= ready_s;
            done_r  <= done_s;
            rdata_r <= rdata_s;
        end
    end

    assign o_ready   = ready_r;
    assign o_done    = done_r;
    assign o_rdata   = rdata_r;
    assign o_sclk    = sclk_r;
    assign o_csb     = csb_r;
    assign o_sdio    = sdio_r;
    assign o_sdio_oe = oe_r;

endmodule

// File: tb/tb_adc_spi_master.sv
// Self-checking bench for adc_spi_master: cycle-offset waveform model plus directed transactions.
// Expectations adapt to ADC_SPI_READBACK_EN.
module tb_adc_spi_master;

`ifdef ADC_SPI_READBACK_EN
    localparam logic RB = 1'b1;
`else
    localparam logic RB = 1'b0;
`endif
    localparam int D   = 4;
    localparam int TOT = 51 * D;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0, valid2 = 1'b0;
    logic        rw = 1'b0;
    logic [12:0] addr = 13'd0;
    logic [7:0]  data = 8'd0;
    logic        sdio_in = 1'b0;
    logic        sdio_in2 = 1'b0;
    logic        ready, done, sclk, csb, sdio, oe;
    logic [7:0]  rdata;
    logic        ready2, done2, sclk2, csb2, sdio2, oe2;
    logic [7:0]  rdata2;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    adc_spi_master #(.CLK_DIV(D)) u_dut (
        .i_clock(clk), .i_RESET(rst), .i_valid(valid), .o_ready(ready), .i_rw(rw),
        .i_addr(addr), .i_data(data), .o_rdata(rdata), .o_done(done), .o_sclk(sclk),
        .o_csb(csb), .o_sdio(sdio), .o_sdio_oe(oe), .i_sdio(sdio_in)
    );

    adc_spi_master #(.CLK_DIV(2)) u_dut2 (
        .i_clock(clk), .i_RESET(rst), .i_valid(valid2), .o_ready(ready2), .i_rw(rw),
        .i_addr(addr), .i_data(data), .o_rdata(rdata2), .o_done(done2), .o_sclk(sclk2),
        .o_csb(csb2), .o_sdio(sdio2), .o_sdio_oe(oe2), .i_sdio(sdio_in2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: k = clock cycles since the accept edge (0 = idle, TOT+1 = done cycle).
    int          k = 0;
    logic        armed = 1'b0;
    logic        after_rst = 1'b0;
    logic [23:0] m_frame = 24'd0;
    logic        m_rd = 1'b0;
    logic [7:0]  m_rval = 8'd0;
    logic [7:0]  m_rdata = 8'd0;
    logic [7:0]  adc_val = 8'd0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            k = 0;
            m_rdata = 8'd0;
            after_rst = 1'b1;
            armed = 1'b1;
        end else begin
            after_rst = 1'b0;
            if (k == 0 || k == TOT + 1) begin
                if (valid) begin
                    k = 1;
                    m_frame = {rw & RB, 2'b00, addr, data};
                    m_rd = rw & RB;
                    m_rval = adc_val;
                end else begin
                    k = 0;
                end
            end else begin
                k = k + 1;
                if (k == TOT + 1 && m_rd) m_rdata = m_rval;
            end
        end
    end

    // Compare every output each cycle; also play the ADC, driving read data after SCLK falls.
    always @(negedge clk) begin
        int  b;
        logic e_sclk;
        b = (k <= D) ? 0 : (k - D - 1) / (2 * D);
        e_sclk = 1'b0;
        if (k >= D + 1 && k <= 49 * D) e_sclk = (((k - D - 1) % (2 * D)) >= D);
        if (armed) begin
            chk("ready", ready, (k == 0 || k == TOT + 1));
            chk("done", done, (k == TOT + 1));
            chk("csb", csb, !(k >= 1 && k <= 50 * D));
            chk("sclk", sclk, e_sclk);
            chk("sdio_oe", oe, !(m_rd && k >= 33 * D + 1 && k <= 50 * D));
            chk("rdata", rdata, m_rdata);
            if (after_rst) chk("sdio_after_reset", sdio, 1'b0);
            else if (k >= 1 && k <= 49 * D) chk("sdio", sdio, m_frame[23 - b]);
        end
        if (m_rd && k >= 33 * D + 1 && k <= 49 * D) sdio_in = m_rval[7 - (b - 16)];
        else sdio_in = 1'b0;
    end

    // Monotonic event monitors; tests read deltas.
    logic        prev_sclk = 1'b0, prev_sclk2 = 1'b0;
    logic [23:0] bits = 24'd0, bits2 = 24'd0;
    int rises = 0, rises2 = 0, oe_low = 0, dones = 0, gap_cnt = 0, last_rise2 = -1;

    always @(negedge clk) begin
        if (sclk === 1'b1 && prev_sclk === 1'b0) begin
            rises++;
            bits = {bits[22:0], sdio};
        end
        prev_sclk = sclk;
        if (oe === 1'b0) oe_low++;
        if (done === 1'b1) dones++;
        if (csb === 1'b1 && ready === 1'b0) gap_cnt++;
        if (sclk2 === 1'b1 && prev_sclk2 === 1'b0) begin
            rises2++;
            bits2 = {bits2[22:0], sdio2};
            if (last_rise2 >= 0) chk("sclk2_period", cyc - last_rise2, 4);
            last_rise2 = cyc;
        end
        prev_sclk2 = sclk2;
    end

    task automatic wait_done(input int t0, output int lat);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", (n < 2000), 1);
        lat = cyc - t0;
    endtask

    task automatic run_req(input logic r, input logic [12:0] a, input logic [7:0] d,
                           output int lat, output int r0, output int o0, output int d0, output int g0);
        int t0;
        @(negedge clk);
        valid = 1'b1; rw = r; addr = a; data = d;
        t0 = cyc; r0 = rises; o0 = oe_low; d0 = dones; g0 = gap_cnt;
        @(negedge clk);
        valid = 1'b0;
        wait_done(t0, lat);
    endtask

    initial begin
        int lat, r0, o0, d0, g0, t0, n;
        logic [7:0] exp_rd;

        repeat (3) @(negedge clk);
        chk("reset_ready", ready, 1'b1);
        chk("reset_csb", csb, 1'b1);
        chk("reset_rdata", rdata, 8'h00);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Write 0x014 <- 0x01
        run_req(1'b0, 13'h014, 8'h01, lat, r0, o0, d0, g0);
        chk("write_latency", lat, 205);
        @(negedge clk);
        chk("write_bits", bits, 24'h001401);
        chk("write_rises", rises - r0, 24);
        chk("write_dones", dones - d0, 1);
        chk("write_gap", gap_cnt - g0, D);

        // Read 0x001, ADC returns 0x09
        adc_val = 8'h09;
        exp_rd = RB ? 8'h09 : 8'h00;
        run_req(1'b1, 13'h001, 8'h00, lat, r0, o0, d0, g0);
        chk("read_latency", lat, 205);
        chk("read_rdata_with_done", rdata, exp_rd);
        @(negedge clk);
        chk("read_bits", bits, RB ? 24'h800100 : 24'h000100);
        chk("read_oe_low_cycles", oe_low - o0, RB ? 17 * D : 0);

        // A write must leave rdata untouched
        run_req(1'b0, 13'h0AB, 8'h5A, lat, r0, o0, d0, g0);
        @(negedge clk);
        chk("write2_bits", bits, 24'h00AB5A);
        chk("write2_rdata_kept", rdata, exp_rd);

        // Back-to-back with valid held high
        @(negedge clk);
        valid = 1'b1; rw = 1'b0; addr = 13'h100; data = 8'hC3;
        t0 = cyc; r0 = rises; g0 = gap_cnt;
        wait_done(t0, lat);
        chk("b2b_first_latency", lat, 205);
        chk("b2b_first_gap", gap_cnt - g0, D);
        data = 8'h3C;
        @(negedge clk);
        chk("b2b_second_accepted", csb, 1'b0);
        valid = 1'b0;
        wait_done(t0, lat);
        chk("b2b_total_latency", lat, 410);
        @(negedge clk);
        chk("b2b_bits", bits, 24'h01003C);
        chk("b2b_rises", rises - r0, 48);
        chk("b2b_gap_total", gap_cnt - g0, 2 * D);

        // Reset at the start of bit 10, with a request pending during reset
        @(negedge clk);
        valid = 1'b1; rw = 1'b0; addr = 13'h014; data = 8'h01;
        d0 = dones;
        @(negedge clk);
        valid = 1'b0;
        repeat (84) @(negedge clk);
        chk("mid_frame_sclk_low_bit10", sclk, 1'b0);
        chk("mid_frame_csb_low", csb, 1'b0);
        rst = 1'b1; valid = 1'b1; addr = 13'h1FF; data = 8'hFF;
        @(negedge clk);
        chk("abort_csb", csb, 1'b1);
        chk("abort_sclk", sclk, 1'b0);
        chk("abort_ready", ready, 1'b1);
        chk("abort_done", done, 1'b0);
        rst = 1'b0; valid = 1'b0;
        n = 0;
        repeat (250) begin
            @(negedge clk);
            if (csb !== 1'b1) n++;
        end
        chk("abort_no_done", dones - d0, 0);
        chk("abort_ignored_request", n, 0);
        run_req(1'b0, 13'h014, 8'h01, lat, r0, o0, d0, g0);
        chk("post_reset_latency", lat, 205);
        @(negedge clk);
        chk("post_reset_bits", bits, 24'h001401);

        // CLK_DIV = 2 instance
        @(negedge clk);
        valid2 = 1'b1; rw = 1'b0; addr = 13'h155; data = 8'hAA;
        t0 = cyc; r0 = rises2;
        @(negedge clk);
        valid2 = 1'b0;
        n = 0;
        while (done2 !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("div2_done_timeout", (n < 2000), 1);
        chk("div2_latency", cyc - t0, 103);
        chk("div2_rises", rises2 - r0, 24);
        chk("div2_bits", bits2, 24'h0155AA);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
